// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state encoding,
// default register-index width and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ctrl_state_t;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int ZERO_REG       = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an FD instruction that reads the destination of a
// load currently in DE. Writes to the zero register never create a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  de_mem_read,
  input  logic [REG_ADDR_W-1:0] de_dst_reg,
  input  logic [REG_ADDR_W-1:0] fd_rs,
  input  logic [REG_ADDR_W-1:0] fd_rt,
  input  logic                  fd_uses_rt,
  output logic                  hazard
);

  logic [REG_ADDR_W-1:0] src [2];
  logic [1:0]            src_used;
  logic [1:0]            src_match;

  assign src[0]   = fd_rs;
  assign src[1]   = fd_rt;
  assign src_used = {fd_uses_rt, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = src_used[gi] & (src[gi] == de_dst_reg);
    end
  endgenerate

  assign hazard = de_mem_read & (de_dst_reg != REG_ADDR_W'(ZERO_REG)) & (|src_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (PC, FD, DE, EM, MW registers).
// Define PIPE_HAZARD_STALL_CNT_EN to add the stall_cycles / flush_events counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] fd_rs,
  input  logic [REG_ADDR_W-1:0] fd_rt,
  input  logic                  fd_uses_rt,
  input  logic                  de_mem_read,
  input  logic [REG_ADDR_W-1:0] de_dst_reg,
  input  logic                  em_mem_access,
  input  logic                  mem_ready,
  input  logic                  em_branch_taken,
  output logic                  pc_wren,
  output logic                  fd_wren,
  output logic                  de_wren,
  output logic                  em_wren,
  output logic                  mw_wren,
  output logic                  fd_flush,
  output logic                  de_flush,
  output logic                  em_flush,
  output logic                  pc_sel
`ifdef PIPE_HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           flush_events
`endif
);

  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

  ctrl_state_t state_reg, state_next;
  ctrl_state_t ret_state_reg, ret_state_next;
  ctrl_state_t eff_state;
  logic [2:0]  cnt_reg, cnt_next;
  logic        hazard;
  logic        freeze;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .de_mem_read (de_mem_read),
    .de_dst_reg  (de_dst_reg),
    .fd_rs       (fd_rs),
    .fd_rt       (fd_rt),
    .fd_uses_rt  (fd_uses_rt),
    .hazard      (hazard)
  );

  assign freeze = em_mem_access & ~mem_ready;
  // On the release cycle of a freeze the controller behaves as the state it left.
  assign eff_state = (state_reg == ST_MEM_WAIT) ? ret_state_reg : state_reg;

  always_comb begin
    pc_wren        = 1'b1;
    fd_wren        = 1'b1;
    de_wren        = 1'b1;
    em_wren        = 1'b1;
    mw_wren        = 1'b1;
    fd_flush       = 1'b0;
    de_flush       = 1'b0;
    em_flush       = 1'b0;
    pc_sel         = 1'b0;
    state_next     = ST_RUN;
    ret_state_next = ST_RUN;
    cnt_next       = cnt_reg;

    if (reset) begin
      {pc_wren, fd_wren, de_wren, em_wren, mw_wren} = 5'b0;
      {fd_flush, de_flush, em_flush}                = 3'b111;
      cnt_next                                      = 3'd0;
    end else if (freeze) begin
      {pc_wren, fd_wren, de_wren, em_wren, mw_wren} = 5'b0;
      state_next     = ST_MEM_WAIT;
      ret_state_next = (state_reg == ST_MEM_WAIT) ? ret_state_reg : state_reg;
    end else if (em_branch_taken) begin
      {fd_flush, de_flush, em_flush} = 3'b111;
      pc_sel                         = 1'b1;
      cnt_next                       = 3'd0;
    end else if (eff_state == ST_LU_STALL) begin
      pc_wren    = 1'b0;
      fd_wren    = 1'b0;
      de_flush   = 1'b1;
      cnt_next   = cnt_reg - 3'd1;
      state_next = (cnt_reg <= 3'd1) ? ST_RUN : ST_LU_STALL;
    end else if (hazard) begin
      pc_wren  = 1'b0;
      fd_wren  = 1'b0;
      de_flush = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_next = ST_LU_STALL;
        cnt_next   = STALL_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      ret_state_reg <= ST_RUN;
      cnt_reg       <= 3'd0;
    end else begin
      state_reg     <= state_next;
      ret_state_reg <= ret_state_next;
      cnt_reg       <= cnt_next;
    end
  end

`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles_reg;
  logic [15:0] flush_events_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg <= 32'd0;
      flush_events_reg <= 16'd0;
    end else begin
      if (!pc_wren && stall_cycles_reg != 32'hFFFF_FFFF)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      // pc_sel marks a branch actually serviced (not one held behind a freeze).
      if (pc_sel)
        flush_events_reg <= flush_events_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;
`endif

endmodule
